jk_register_bank: RTL and testbench
===================================

// Module: jk_register_bank
// PURPOSE
//   WIDTH-bit register bank of JK flip-flop cells with a shared clock/reset and
//   four operating modes: per-bit JK, parallel load, shift-left, binary up-count.
//   Generalised successor of the single-bit JK cell. Used as a general-purpose
//   control/status register and event counter in lab datapaths.
//   Also reports which bits changed on each update and flags counter wrap.
// PARAMETERS
//   WIDTH      8   number of register bits; legal range 1..32
//   RESET_VAL  0   value loaded into q on reset; WIDTH bits, upper bits ignored
// PORTS
//   clk      in   1      rising-edge clock
//   rst      in   1      synchronous reset, active-high
//   en       in   1      update enable; 0 = hold all state
//   mode     in   2      00 JK, 01 LOAD, 10 SHIFT, 11 COUNT
//   j        in   WIDTH  per-bit J inputs (JK mode only)
//   k        in   WIDTH  per-bit K inputs (JK mode only)
//   d        in   WIDTH  parallel load data (LOAD mode only)
//   ser_in   in   1      serial input into bit 0 (SHIFT mode only)
//   q        out  WIDTH  register contents (registered)
//   changed  out  WIDTH  registered: bit i = 1 if q[i] changed on the last edge
//   carry    out  1      registered 1-cycle pulse: COUNT wrapped all-ones -> 0
//   ser_out  out  1      combinational q[WIDTH-1] (bit lost on next shift)
// BEHAVIOUR
//   - All state updates on rising clk only; no asynchronous paths.
//   - Reset: rst=1 at edge -> q=RESET_VAL, changed=0, carry=0. rst overrides
//     en and mode; a reset mid-count or mid-shift discards the operation.
//   - en=0 (rst=0): q holds; changed=0; carry=0 on that edge.
//   - en=1, mode 00 JK, per bit i, independently:
//       j[i]k[i]=00 hold, 01 clear, 10 set, 11 toggle.
//   - en=1, mode 01 LOAD: q <= d.
//   - en=1, mode 10 SHIFT: q <= {q[WIDTH-2:0], ser_in}; WIDTH=1: q <= ser_in.
//   - en=1, mode 11 COUNT: q <= q + 1 modulo 2^WIDTH (WIDTH-bit arithmetic,
//     no extra bit kept). carry <= 1 on that edge iff q was all ones.
//   - carry is 0 on every edge that is not a COUNT wrap; never stretched.
//   - changed <= q_next ^ q on every non-reset edge (0 when holding).
//   - Latency: one cycle from inputs sampled to q/changed/carry visible.
//   - Inputs unused by the active mode are ignored (j/k/d/ser_in don't-care).
//   - mode change takes effect at the same edge it is sampled; no pipeline.
//   - ser_out tracks q combinationally; it is not reset separately.
// TESTING
//   1 Reset: WIDTH=8, RESET_VAL=8'hA5, rst=1 one edge -> q=A5, changed=00,
//     carry=0; rst=1 with en=1,mode=11 -> q stays A5.
//   2 JK: q=F0, j=0F, k=3C, mode 00 -> q=CF (bits 7..6 hold, 5..4 clear,
//     3..2 toggle, 1..0 set), changed=3F.
//   3 LOAD/hold: mode 01,d=5A -> q=5A; then en=0 with d=FF -> q=5A, changed=00.
//   4 SHIFT: q=81, mode 10, ser_in=1 -> q=03, ser_out was 1 before edge;
//     WIDTH=1 build: ser_in=0 -> q=0.
//   5 COUNT wrap: q=FE, mode 11, 3 edges -> q=FF,00,01; carry=0,1,0;
//     changed after wrap edge = FF.
//   6 Random: 1000 cycles random rst/en/mode/j/k/d/ser_in vs reference model,
//     WIDTH in {1,8,32}; q, changed, carry compared every cycle.

Source files
------------

// File: rtl/jk_register_bank_if.sv
// Bus interface for jk_register_bank.
// Purpose : groups the control, data and status signals of the JK register bank.
// Signals : en, mode[1:0], j/k/d[WIDTH], ser_in   (master -> slave)
//           q, changed[WIDTH], carry, ser_out     (slave -> master)
interface jk_register_bank_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] d;
  logic             ser_in;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] changed;
  logic             carry;
  logic             ser_out;

  modport master (
    output en, mode, j, k, d, ser_in,
    input  q, changed, carry, ser_out
  );

  modport slave (
    input  en, mode, j, k, d, ser_in,
    output q, changed, carry, ser_out
  );
endinterface

// File: rtl/jk_register_bank.sv
// WIDTH-bit register bank built from JK cells.
// Purpose : general control/status register and event counter with four modes
//           (per-bit JK, parallel load, shift-left, binary up-count), a per-bit
//           change report and a counter-wrap pulse.
// Ports   : clk  - rising-edge clock
//           rst  - synchronous reset, active-high
//           bus  - jk_register_bank_if.slave (en, mode, j, k, d, ser_in in;
//                  q, changed, carry, ser_out out)
module jk_register_bank #(
  parameter int          WIDTH     = 8,
  parameter logic [31:0] RESET_VAL = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  jk_register_bank_if.slave bus
);

  localparam logic [1:0] MODE_JK    = 2'b00;
  localparam logic [1:0] MODE_LOAD  = 2'b01;
  localparam logic [1:0] MODE_SHIFT = 2'b10;
  localparam logic [1:0] MODE_COUNT = 2'b11;

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] changed_q, changed_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] shift_val;

  // A one-bit bank has nothing to shift along, so the serial input simply
  // replaces the bit.
  generate
    if (WIDTH == 1) begin : g_shift_w1
      assign shift_val = bus.ser_in;
    end else begin : g_shift_wn
      assign shift_val = {q_q[WIDTH-2:0], bus.ser_in};
    end
  endgenerate

  always_comb begin
    q_d     = q_q;
    carry_d = 1'b0;
    if (bus.en) begin
      unique case (bus.mode)
        // Characteristic JK equation: 00 hold, 01 clear, 10 set, 11 toggle.
        MODE_JK:    q_d = (q_q & ~bus.k) | (~q_q & bus.j);
        MODE_LOAD:  q_d = bus.d;
        MODE_SHIFT: q_d = shift_val;
        MODE_COUNT: begin
          q_d     = q_q + WIDTH'(1);
          carry_d = &q_q;
        end
        default:    q_d = q_q;
      endcase
    end
    changed_d = q_d ^ q_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q       <= RESET_VAL[WIDTH-1:0];
      changed_q <= '0;
      carry_q   <= 1'b0;
    end else begin
      q_q       <= q_d;
      changed_q <= changed_d;
      carry_q   <= carry_d;
    end
  end

  assign bus.q       = q_q;
  assign bus.changed = changed_q;
  assign bus.carry   = carry_q;
  assign bus.ser_out = q_q[WIDTH-1];

endmodule

// File: tb/tb_jk_register_bank.sv
module tb_jk_register_bank;

  logic clk;
  logic rst;

  jk_register_bank_if #(.WIDTH(1))  if1  ();
  jk_register_bank_if #(.WIDTH(8))  if8  ();
  jk_register_bank_if #(.WIDTH(32)) if32 ();

  jk_register_bank #(.WIDTH(1),  .RESET_VAL(32'hA5)) u_dut1  (.clk(clk), .rst(rst), .bus(if1));
  jk_register_bank #(.WIDTH(8),  .RESET_VAL(32'hA5)) u_dut8  (.clk(clk), .rst(rst), .bus(if8));
  jk_register_bank #(.WIDTH(32), .RESET_VAL(32'hA5)) u_dut32 (.clk(clk), .rst(rst), .bus(if32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // reference state per width: index 0 -> W1, 1 -> W8, 2 -> W32
  int          wid [3] = '{1, 8, 32};
  logic [31:0] mq  [3];
  logic [31:0] mchg[3];
  logic        mcar[3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp)
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    else
      n_pass++;
  endtask

  function automatic logic [31:0] mask_of(input int w);
    return (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
  endfunction

  // Behavioural model: written from the mode rules, bit by bit / arithmetically.
  task automatic model_step(input int w, input logic [31:0] q,
                            input logic r, input logic e, input logic [1:0] m,
                            input logic [31:0] jj, input logic [31:0] kk,
                            input logic [31:0] dd, input logic s,
                            output logic [31:0] nq, output logic [31:0] nchg,
                            output logic ncar);
    logic [31:0] msk;
    msk  = mask_of(w);
    nq   = q;
    ncar = 1'b0;
    if (r) begin
      nq   = 32'hA5 & msk;
      nchg = 32'h0;
      return;
    end
    if (e) begin
      case (m)
        2'd0: for (int b = 0; b < w; b++) begin
                case ({jj[b], kk[b]})
                  2'b01:   nq[b] = 1'b0;
                  2'b10:   nq[b] = 1'b1;
                  2'b11:   nq[b] = ~q[b];
                  default: nq[b] = q[b];
                endcase
              end
        2'd1: nq = dd & msk;
        2'd2: nq = ((q << 1) | 32'(s)) & msk;
        default: begin
          nq   = (q + 32'd1) & msk;
          ncar = (q == msk);
        end
      endcase
    end
    nchg = nq ^ q;
  endtask

  task automatic cycle(input logic r, input logic e, input logic [1:0] m,
                       input logic [31:0] jj, input logic [31:0] kk,
                       input logic [31:0] dd, input logic s);
    logic [31:0] nq, nc;
    logic        ncar;
    rst = r;
    if1.en  = e;  if1.mode  = m;  if1.j  = jj[0:0]; if1.k  = kk[0:0]; if1.d  = dd[0:0]; if1.ser_in  = s;
    if8.en  = e;  if8.mode  = m;  if8.j  = jj[7:0]; if8.k  = kk[7:0]; if8.d  = dd[7:0]; if8.ser_in  = s;
    if32.en = e;  if32.mode = m;  if32.j = jj;      if32.k = kk;      if32.d = dd;      if32.ser_in = s;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      model_step(wid[i], mq[i], r, e, m, jj, kk, dd, s, nq, nc, ncar);
      mq[i] = nq; mchg[i] = nc; mcar[i] = ncar;
    end
  endtask

  task automatic check_model();
    chk("rnd_q1",    32'(if1.q),        mq[0]);
    chk("rnd_chg1",  32'(if1.changed),  mchg[0]);
    chk("rnd_car1",  32'(if1.carry),    32'(mcar[0]));
    chk("rnd_q8",    32'(if8.q),        mq[1]);
    chk("rnd_chg8",  32'(if8.changed),  mchg[1]);
    chk("rnd_car8",  32'(if8.carry),    32'(mcar[1]));
    chk("rnd_sout8", 32'(if8.ser_out),  32'(mq[1][7]));
    chk("rnd_q32",   if32.q,            mq[2]);
    chk("rnd_chg32", if32.changed,      mchg[2]);
    chk("rnd_car32", 32'(if32.carry),   32'(mcar[2]));
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      mq[i] = 32'h0; mchg[i] = 32'h0; mcar[i] = 1'b0;
    end

    // reset
    cycle(1'b1, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 1'b0);
    chk("rst_q",   32'(if8.q),       32'hA5);
    chk("rst_chg", 32'(if8.changed), 32'h00);
    chk("rst_car", 32'(if8.carry),   32'h0);
    chk("rst_q32", if32.q,           32'h0000_00A5);
    chk("rst_q1",  32'(if1.q),       32'h1);
    cycle(1'b1, 1'b1, 2'd3, 32'h0, 32'h0, 32'h0, 1'b0);
    chk("rst_over_cnt", 32'(if8.q), 32'hA5);

    // JK per-bit behaviour
    cycle(1'b0, 1'b1, 2'd1, 32'h0, 32'h0, 32'hF0, 1'b0);
    cycle(1'b0, 1'b1, 2'd0, 32'h0F, 32'h3C, 32'h0, 1'b0);
    chk("jk_q",   32'(if8.q),       32'hCF);
    chk("jk_chg", 32'(if8.changed), 32'h3F);

    // load then hold
    cycle(1'b0, 1'b1, 2'd1, 32'h0, 32'h0, 32'h5A, 1'b0);
    chk("load_q", 32'(if8.q), 32'h5A);
    cycle(1'b0, 1'b0, 2'd1, 32'h0, 32'h0, 32'hFF, 1'b0);
    chk("hold_q",   32'(if8.q),       32'h5A);
    chk("hold_chg", 32'(if8.changed), 32'h00);

    // shift; W1 gets 1 loaded first so the shifted-in 0 is visible
    cycle(1'b0, 1'b1, 2'd1, 32'h0, 32'h0, 32'h81, 1'b0);
    chk("sout_pre", 32'(if8.ser_out), 32'h1);
    cycle(1'b0, 1'b1, 2'd2, 32'h0, 32'h0, 32'h0, 1'b1);
    chk("shift_q", 32'(if8.q), 32'h03);
    cycle(1'b0, 1'b1, 2'd1, 32'h0, 32'h0, 32'h1, 1'b0);
    cycle(1'b0, 1'b1, 2'd2, 32'h0, 32'h0, 32'h0, 1'b0);
    chk("shift_w1", 32'(if1.q), 32'h0);

    // count across wrap
    cycle(1'b0, 1'b1, 2'd1, 32'h0, 32'h0, 32'hFE, 1'b0);
    cycle(1'b0, 1'b1, 2'd3, 32'h0, 32'h0, 32'h0, 1'b0);
    chk("cnt1_q",   32'(if8.q),     32'hFF);
    chk("cnt1_car", 32'(if8.carry), 32'h0);
    cycle(1'b0, 1'b1, 2'd3, 32'h0, 32'h0, 32'h0, 1'b0);
    chk("cnt2_q",   32'(if8.q),       32'h00);
    chk("cnt2_car", 32'(if8.carry),   32'h1);
    chk("cnt2_chg", 32'(if8.changed), 32'hFF);
    cycle(1'b0, 1'b1, 2'd3, 32'h0, 32'h0, 32'h0, 1'b0);
    chk("cnt3_q",   32'(if8.q),     32'h01);
    chk("cnt3_car", 32'(if8.carry), 32'h0);

    // 32-bit wrap
    cycle(1'b0, 1'b1, 2'd1, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0);
    cycle(1'b0, 1'b1, 2'd3, 32'h0, 32'h0, 32'h0, 1'b0);
    chk("cnt32_q",   if32.q,             32'h0);
    chk("cnt32_car", 32'(if32.carry),    32'h1);

    // randomized run against the reference model, all widths in parallel;
    // counting is weighted up so wraps happen on the narrow banks
    for (int n = 0; n < 1000; n++) begin
      logic        r, e, s;
      logic [1:0]  m;
      logic [31:0] jj, kk, dd;
      r  = ($urandom_range(0, 31) == 0);
      e  = ($urandom_range(0, 3) != 0);
      m  = ($urandom_range(0, 2) == 0) ? 2'd3 : 2'($urandom_range(0, 3));
      jj = $urandom();
      kk = $urandom();
      dd = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)) : $urandom();
      s  = 1'($urandom_range(0, 1));
      cycle(r, e, m, jj, kk, dd, s);
      check_model();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
